// File: rtl/rf_wr_arbiter_if.sv
// Register-file write-port arbitration bundle: WB write, multi-cycle result, issue marking,
// hazard queries and the arbitrated register-file write. master = pipeline side, slave = arbiter.
interface rf_wr_arbiter_if;
    logic        pipe_wr;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic        mc_valid;
    logic [4:0]  mc_addr;
    logic [31:0] mc_data;
    logic        mc_ready;
    logic        issue_set;
    logic [4:0]  issue_addr;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic        rs_busy;
    logic        rt_busy;
    logic        rd_busy;
    logic        rf_wr;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        stall_req;

    modport master (
        output pipe_wr, pipe_addr, pipe_data,
        output mc_valid, mc_addr, mc_data,
        input  mc_ready,
        output issue_set, issue_addr,
        output rs_addr, rt_addr, rd_addr,
        input  rs_busy, rt_busy, rd_busy,
        input  rf_wr, rf_addr, rf_data,
        input  stall_req
    );

    modport slave (
        input  pipe_wr, pipe_addr, pipe_data,
        input  mc_valid, mc_addr, mc_data,
        output mc_ready,
        input  issue_set, issue_addr,
        input  rs_addr, rt_addr, rd_addr,
        output rs_busy, rt_busy, rd_busy,
        output rf_wr, rf_addr, rf_data,
        output stall_req
    );
endinterface

// File: rtl/rf_wr_arbiter.sv
// Shares the RF write port between WB and a FIFO of multi-cycle results, with a busy scoreboard.
// Zero-latency grant; FIFO backpressures via mc_ready. Optional starvation stall: RFARB_STARVE_EN.
module rf_wr_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input logic            clk,
    input logic            reset,
    rf_wr_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] ptr_t;

    logic [4:0]  addr_mem_q [DEPTH];
    logic [31:0] data_mem_q [DEPTH];
    ptr_t        wr_ptr_q, wr_ptr_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    logic [31:0] busy_q, busy_d;

    logic        empty, full, push, pop;
    logic        pipe_ok, pipe_gnt, force_head;
    logic [4:0]  head_addr;
    logic [31:0] head_data;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_addr = addr_mem_q[rd_ptr_q[AW-1:0]];
    assign head_data = data_mem_q[rd_ptr_q[AW-1:0]];

    assign push     = bus.mc_valid && !full && (bus.mc_addr != 5'd0);
    assign pipe_ok  = bus.pipe_wr && (bus.pipe_addr != 5'd0);
    assign pipe_gnt = pipe_ok && !force_head;
    assign pop      = !empty && (force_head || !pipe_ok);

    assign bus.mc_ready = !full;
    assign bus.rs_busy  = busy_q[bus.rs_addr];
    assign bus.rt_busy  = busy_q[bus.rt_addr];
    assign bus.rd_busy  = busy_q[bus.rd_addr];

    always_comb begin
        bus.rf_wr   = pop || pipe_gnt;
        bus.rf_addr = 5'd0;
        bus.rf_data = 32'd0;
        if (pop) begin
            bus.rf_addr = head_addr;
            bus.rf_data = head_data;
        end else if (pipe_gnt) begin
            bus.rf_addr = bus.pipe_addr;
            bus.rf_data = bus.pipe_data;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
    end

    // Clear on commit first so a same-cycle issue to that register wins.
    always_comb begin
        busy_d = busy_q;
        if (pop) begin
            busy_d[head_addr] = 1'b0;
        end
        if (bus.issue_set) begin
            busy_d[bus.issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            busy_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            busy_q   <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[wr_ptr_q[AW-1:0]] <= bus.mc_addr;
            data_mem_q[wr_ptr_q[AW-1:0]] <= bus.mc_data;
        end
    end

`ifdef RFARB_STARVE_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          stall_req_q, stall_req_d;

    always_comb begin
        wait_cnt_d  = '0;
        stall_req_d = 1'b0;
        if (!empty && !pop) begin
            if (wait_cnt_q == CW'(STARVE_LIMIT - 1)) begin
                stall_req_d = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q  <= '0;
            stall_req_q <= 1'b0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            stall_req_q <= stall_req_d;
        end
    end

    assign force_head    = stall_req_q;
    assign bus.stall_req = stall_req_q;
`else
    localparam bit LIMIT_OK = (STARVE_LIMIT >= 1);
    assign force_head    = 1'b0 & LIMIT_OK;
    assign bus.stall_req = 1'b0;
`endif
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Bench for rf_wr_arbiter: directed scenarios then random traffic, checked every cycle against
// a queue/array reference model of the arbitration, FIFO and scoreboard rules.
module tb_rf_wr_arbiter;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    rf_wr_arbiter_if bus ();

    rf_wr_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    ent_t        q_m[$];
    bit [31:0]   busy_m;
    int          wait_m;
    bit          stall_m;
    logic [4:0]  obs_log[$];
    logic        last_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_m.delete();
        busy_m  = '0;
        wait_m  = 0;
        stall_m = 1'b0;
    endtask

    // One clock: check all outputs mid-cycle against the model, then advance the model at the edge.
    task automatic step();
        bit   pipe_ok, pg, hg;
        ent_t h;
        int   sz;
        @(negedge clk);
        sz      = q_m.size();
        pipe_ok = bus.pipe_wr && (bus.pipe_addr != 5'd0);
        pg      = pipe_ok && !stall_m;
        hg      = (sz > 0) && (stall_m || !pipe_ok);
        h       = (sz > 0) ? q_m[0] : '0;
        chk("rf_wr", bus.rf_wr, pg || hg);
        if (hg) begin
            chk("rf_addr_head", bus.rf_addr, h.a);
            chk("rf_data_head", bus.rf_data, h.d);
        end else if (pg) begin
            chk("rf_addr_pipe", bus.rf_addr, bus.pipe_addr);
            chk("rf_data_pipe", bus.rf_data, bus.pipe_data);
        end
        chk("mc_ready", bus.mc_ready, sz < DEPTH);
        chk("rs_busy", bus.rs_busy, busy_m[bus.rs_addr]);
        chk("rt_busy", bus.rt_busy, busy_m[bus.rt_addr]);
        chk("rd_busy", bus.rd_busy, busy_m[bus.rd_addr]);
        chk("stall_req", bus.stall_req, stall_m);
        last_stall = bus.stall_req;
        if (bus.rf_wr === 1'b1) obs_log.push_back(bus.rf_addr);
        @(posedge clk);
        if (!reset) begin
            if (hg) begin
                void'(q_m.pop_front());
                busy_m[h.a] = 1'b0;
            end
`ifdef RFARB_STARVE_EN
            stall_m = 1'b0;
            if (sz > 0 && !hg) begin
                if (wait_m == LIMIT - 1) begin
                    stall_m = 1'b1;
                    wait_m  = 0;
                end else begin
                    wait_m++;
                end
            end else begin
                wait_m = 0;
            end
`endif
            if (bus.mc_valid && sz < DEPTH && bus.mc_addr != 5'd0)
                q_m.push_back({bus.mc_addr, bus.mc_data});
            if (bus.issue_set && bus.issue_addr != 5'd0)
                busy_m[bus.issue_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.pipe_wr = 1'b0; bus.pipe_addr = '0; bus.pipe_data = '0;
        bus.mc_valid = 1'b0; bus.mc_addr = '0; bus.mc_data = '0;
        bus.issue_set = 1'b0; bus.issue_addr = '0;
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * DEPTH && q_m.size() > 0; i++) step();
        chk("drain_mc_ready", bus.mc_ready, 1'b1);
    endtask

    initial begin
        int stall_at;
        int stall_cnt;
        logic [4:0] exp_a;
        reset = 1'b1;
        idle_inputs();
        bus.rs_addr = '0; bus.rt_addr = '0; bus.rd_addr = '0;
        model_reset();
        step(); step();
        reset = 1'b0;
        step();

        // WB and multi-cycle result arrive together: WB first, FIFO head next cycle.
        bus.pipe_wr = 1'b1; bus.pipe_addr = 5'd5; bus.pipe_data = 32'h11;
        bus.mc_valid = 1'b1; bus.mc_addr = 5'd6; bus.mc_data = 32'h22;
        #2;
        chk("t2_c0_wr", bus.rf_wr, 1'b1);
        chk("t2_c0_addr", bus.rf_addr, 5'd5);
        chk("t2_c0_data", bus.rf_data, 32'h11);
        step();
        idle_inputs();
        #2;
        chk("t2_c1_addr", bus.rf_addr, 5'd6);
        chk("t2_c1_data", bus.rf_data, 32'h22);
        step(); step();

        // Busy scoreboard from issue to multi-cycle commit.
        bus.issue_set = 1'b1; bus.issue_addr = 5'd8; bus.rs_addr = 5'd8;
        step();
        bus.issue_set = 1'b0;
        #2;
        chk("t3_busy_set", bus.rs_busy, 1'b1);
        step(); step(); step();
        bus.mc_valid = 1'b1; bus.mc_addr = 5'd8; bus.mc_data = 32'hABCD;
        step();
        bus.mc_valid = 1'b0;
        #2;
        chk("t3_commit_addr", bus.rf_addr, 5'd8);
        chk("t3_busy_at_commit", bus.rs_busy, 1'b1);
        step();
        #2;
        chk("t3_busy_clear", bus.rs_busy, 1'b0);

        // Reset in the middle of traffic discards FIFO and scoreboard.
        bus.pipe_wr = 1'b1; bus.pipe_addr = 5'd4; bus.pipe_data = 32'h44;
        bus.issue_set = 1'b1; bus.issue_addr = 5'd20; bus.rs_addr = 5'd20;
        bus.mc_valid = 1'b1; bus.mc_addr = 5'd21; bus.mc_data = 32'h55;
        step(); step();
        reset = 1'b1;
        model_reset();
        bus.pipe_wr = 1'b0;
        #2;
        chk("t1_rf_wr", bus.rf_wr, 1'b0);
        chk("t1_mc_ready", bus.mc_ready, 1'b1);
        chk("t1_rs_busy", bus.rs_busy, 1'b0);
        chk("t1_stall", bus.stall_req, 1'b0);
        step();
        reset = 1'b0;
        idle_inputs();
        step();
        chk("t1_after_rf_wr", bus.rf_wr, 1'b0);

        // Fill the FIFO while WB holds the port; a fifth result must wait, not vanish.
        bus.pipe_wr = 1'b1; bus.pipe_addr = 5'd2; bus.pipe_data = 32'h2;
        for (int i = 0; i < 4; i++) begin
            bus.mc_valid = 1'b1; bus.mc_addr = 5'(10 + i); bus.mc_data = 32'(100 + i);
            step();
        end
        bus.mc_addr = 5'd14; bus.mc_data = 32'd104;
        #2;
        chk("t4_full", bus.mc_ready, 1'b0);
        step(); step();
        obs_log.delete();
        bus.pipe_wr = 1'b0;
        for (int i = 0; i < 8 && bus.mc_valid; i++) begin
            step();
            if (q_m.size() > 0 && q_m[q_m.size()-1].a == 5'd14) bus.mc_valid = 1'b0;
        end
        bus.mc_valid = 1'b0;
        drain();
        chk("t4_commit_count", obs_log.size(), 5);
        for (int i = 0; i < 5 && i < obs_log.size(); i++) begin
            exp_a = 5'(10 + i);
            chk("t4_commit_order", obs_log[i], exp_a);
        end

        // One FIFO entry against a permanently busy WB stage.
        bus.pipe_wr = 1'b1; bus.pipe_addr = 5'd3; bus.pipe_data = 32'h33;
        bus.mc_valid = 1'b1; bus.mc_addr = 5'd9; bus.mc_data = 32'h99;
        step();
        bus.mc_valid = 1'b0;
        stall_at = 0;
        stall_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (last_stall === 1'b1) begin
                stall_cnt++;
                if (stall_at == 0) stall_at = i;
            end
        end
`ifdef RFARB_STARVE_EN
        chk("t5_stall_cycle", stall_at, 9);
        chk("t5_stall_count", stall_cnt, 1);
`else
        chk("t5_no_stall", stall_cnt, 0);
        chk("t5_entry_waits", bus.mc_ready, 1'b1);
`endif
        bus.pipe_wr = 1'b0;
        drain();

        // Register 0 is never written, queued or marked busy.
        bus.pipe_wr = 1'b1; bus.pipe_addr = 5'd0; bus.pipe_data = 32'hDEAD;
        bus.mc_valid = 1'b1; bus.mc_addr = 5'd0; bus.mc_data = 32'hBEEF;
        bus.issue_set = 1'b1; bus.issue_addr = 5'd0; bus.rs_addr = 5'd0;
        #2;
        chk("t6_rf_wr", bus.rf_wr, 1'b0);
        step();
        idle_inputs();
        #2;
        chk("t6_rf_wr_next", bus.rf_wr, 1'b0);
        chk("t6_rs_busy", bus.rs_busy, 1'b0);
        step();

        // Random traffic; a refused multi-cycle result is held until accepted.
        for (int i = 0; i < 400; i++) begin
            bus.pipe_wr   = ($urandom_range(0, 99) < 55);
            bus.pipe_addr = 5'($urandom_range(0, 31));
            bus.pipe_data = $urandom;
            if (!(bus.mc_valid && q_m.size() >= DEPTH)) begin
                bus.mc_valid = ($urandom_range(0, 99) < 40);
                bus.mc_addr  = 5'($urandom_range(0, 31));
                bus.mc_data  = $urandom;
            end
            bus.issue_set  = ($urandom_range(0, 99) < 20);
            bus.issue_addr = 5'($urandom_range(0, 31));
            bus.rs_addr    = 5'($urandom_range(0, 31));
            bus.rt_addr    = 5'($urandom_range(0, 31));
            bus.rd_addr    = 5'($urandom_range(0, 31));
            step();
        end
        idle_inputs();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
